gearbox_rx_66b: RTL and testbench

- Per-lane RX gearbox. Converts the continuous 64-bit SERDES word stream into 66-bit blocks (2-bit sync header plus 64-bit payload) for block sync, alignment-marker lock and the descrambler in pcs_rx.
- Mirror of the pcs_tx 66->64 gearbox.
- Accepts a one-bit slip request from block sync so the block boundary can be walked until header lock is reached.
- One instance per lane, so 4 instances for 40GBASE and 1 for 10GBASE.

---
 rtl/gearbox_rx_66b.sv | 119 +++++++++++
 tb/tb_gearbox_rx_66b.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_rx_66b.sv
// rtl/gearbox_rx_66b.sv - per-lane RX 64->66 gearbox with bit slip; optional slip counter under GEARBOX_RX_SLIP_CNT_EN
module gearbox_rx_66b #(
   parameter int DATA_W  = 64,
   parameter int HEAD_W  = 2,
   parameter int BLOCK_W = HEAD_W + DATA_W,
   parameter int BUF_W   = BLOCK_W + DATA_W - 1
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              serdes_v_i,
   input  logic [DATA_W-1:0] serdes_data_i,
   input  logic              slip_i,
   output logic              valid_o,
   output logic [HEAD_W-1:0] head_o,
   output logic [DATA_W-1:0] data_o
`ifdef GEARBOX_RX_SLIP_CNT_EN
   ,
   output logic [15:0]       slip_cnt_o
`endif
);

   localparam logic [7:0] BLOCK_W8 = 8'(BLOCK_W);
   localparam logic [7:0] DATA_W8  = 8'(DATA_W);

   // Bit store: oldest bit at bit 0, only the low fill_q bits are meaningful.
   logic [BUF_W-1:0]  bits_q, bits_d;
   logic [6:0]        fill_q, fill_d;
   logic              slip_pend_q, slip_pend_d;
   logic              valid_q;
   logic [HEAD_W-1:0] head_q;
   logic [DATA_W-1:0] data_q;

   logic [7:0]        avail_raw, avail;
   logic [BUF_W-1:0]  keep_mask, word_ext, cat_raw, cat;
   logic              slip_req, do_slip, emit;

   // Append the incoming word above the held bits, apply at most one slip, decide on a block.
   always_comb begin
      avail_raw   = {1'b0, fill_q} + (serdes_v_i ? DATA_W8 : 8'd0);
      keep_mask   = ~({BUF_W{1'b1}} << fill_q);
      word_ext    = {{(BUF_W-DATA_W){1'b0}}, serdes_data_i};
      cat_raw     = (bits_q & keep_mask) | (serdes_v_i ? (word_ext << fill_q) : {BUF_W{1'b0}});
      slip_req    = slip_i | slip_pend_q;
      do_slip     = slip_req && (avail_raw != 8'd0);
      cat         = do_slip ? (cat_raw >> 1) : cat_raw;
      avail       = avail_raw - {7'd0, do_slip};
      emit        = (avail >= BLOCK_W8);
      // A slip with nothing to drop waits here for the next valid word.
      slip_pend_d = slip_req && !do_slip;
      if (emit) begin
         bits_d = cat >> BLOCK_W;
         fill_d = 7'(avail - BLOCK_W8);
      end else begin
         bits_d = cat;
         fill_d = avail[6:0];
      end
   end

   // Control state and registered block outputs; head/data hold between blocks.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         valid_q     <= 1'b0;
         head_q      <= '0;
         data_q      <= '0;
         fill_q      <= 7'd0;
         slip_pend_q <= 1'b0;
      end else begin
         valid_q     <= emit;
         fill_q      <= fill_d;
         slip_pend_q <= slip_pend_d;
         if (emit) begin
            head_q <= cat[HEAD_W-1:0];
            data_q <= cat[BLOCK_W-1:HEAD_W];
         end
      end
   end

   // Bit store needs no reset: fill_q masks whatever it holds.
   always_ff @(posedge clk) begin
      bits_q <= bits_d;
   end

   assign valid_o = valid_q;
   assign head_o  = head_q;
   assign data_o  = data_q;

`ifdef GEARBOX_RX_SLIP_CNT_EN
   logic [15:0] slip_cnt_q;

   // Count executed slips, saturating so a stuck lock search never wraps to a small value.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         slip_cnt_q <= 16'd0;
      end else if (do_slip && (slip_cnt_q != 16'hFFFF)) begin
         slip_cnt_q <= slip_cnt_q + 16'd1;
      end
   end

   assign slip_cnt_o = slip_cnt_q;
`else
   // Slip counting disabled: do_slip only steers the bit shift above.
`endif

`ifndef SYNTHESIS
   logic short_valid_q;

   // Sanity: fill bounded, and no back-to-back blocks built from too few bits.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         short_valid_q <= 1'b0;
      end else begin
         short_valid_q <= emit && (avail < BLOCK_W8);
         assert (fill_q <= 7'd65);
         assert (!(short_valid_q && emit && (avail < BLOCK_W8)));
      end
   end
`endif

endmodule

// File: tb/tb_gearbox_rx_66b.sv
// tb/tb_gearbox_rx_66b.sv - directed self-checking bench for gearbox_rx_66b
module tb_gearbox_rx_66b;

   logic        clk = 1'b0;
   logic        nreset;
   logic        serdes_v_i;
   logic [63:0] serdes_data_i;
   logic        slip_i;
   logic        valid_o;
   logic [1:0]  head_o;
   logic [63:0] data_o;
`ifdef GEARBOX_RX_SLIP_CNT_EN
   logic [15:0] slip_cnt_o;
`endif

   gearbox_rx_66b dut (
      .clk           (clk),
      .nreset        (nreset),
      .serdes_v_i    (serdes_v_i),
      .serdes_data_i (serdes_data_i),
      .slip_i        (slip_i),
      .valid_o       (valid_o),
      .head_o        (head_o),
      .data_o        (data_o)
`ifdef GEARBOX_RX_SLIP_CNT_EN
      ,
      .slip_cnt_o    (slip_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int npass  = 0;
   int ntotal = 0;

   logic        stream   [0:8999];
   logic        gap_at   [0:299];
   logic        slip_at  [0:299];
   logic        vhist    [0:299];
   int          fillhist [0:299];
   logic [65:0] rx       [0:255];
   int          nrx;
   int          fillmax;

   function automatic logic [65:0] exp_blk(input int k);
      logic [63:0] d;
      d = 64'hA5A5_0000_0000_0000 + 64'(k);
      return {d, 2'b01};
   endfunction

   task automatic build(input int nblk, input int junk);
      logic [65:0] b;
      for (int i = 0; i < 9000; i++) stream[i] = 1'b0;
      for (int i = 0; i < junk; i++) stream[i] = 1'b1;
      for (int k = 0; k < nblk; k++) begin
         b = exp_blk(k);
         for (int j = 0; j < 66; j++) stream[junk + 66*k + j] = b[j];
      end
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 300; i++) begin
         gap_at[i]  = 1'b0;
         slip_at[i] = 1'b0;
      end
   endtask

   // Feeds nwords words (skipping gap cycles), then nflush idle cycles; records outputs.
   task automatic run(input int nwords, input int nflush);
      int w = 0;
      int f = 0;
      int c = 0;
      logic [63:0] wd;
      nrx = 0;
      fillmax = 0;
      while ((w < nwords) || (f < nflush)) begin
         if ((w < nwords) && !gap_at[c]) begin
            for (int b = 0; b < 64; b++) wd[b] = stream[64*w + b];
            serdes_data_i = wd;
            serdes_v_i = 1'b1;
            w++;
         end else begin
            serdes_v_i = 1'b0;
            serdes_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
            if (w >= nwords) f++;
         end
         slip_i = slip_at[c];
         @(posedge clk); #1;
         vhist[c] = valid_o;
         fillhist[c] = int'(dut.fill_q);
         if (fillhist[c] > fillmax) fillmax = fillhist[c];
         if (valid_o) begin
            rx[nrx] = {data_o, head_o};
            nrx++;
         end
         c++;
      end
      serdes_v_i = 1'b0;
      slip_i = 1'b0;
   endtask

   function automatic int count_bad(input int first, input int n);
      int bad = 0;
      for (int i = first; i < first + n; i++)
         if (rx[i] !== exp_blk(i)) bad++;
      return bad;
   endfunction

   task automatic do_reset();
      nreset = 1'b0;
      serdes_v_i = 1'b0;
      slip_i = 1'b0;
      serdes_data_i = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      nreset = 1'b1;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      serdes_v_i = 1'b1;
      serdes_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
      slip_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ntotal++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o); else npass++;
      ntotal++; if (head_o !== 2'b00) $display("FAIL reset_head got %b want 00", head_o); else npass++;
      ntotal++; if (data_o !== 64'd0) $display("FAIL reset_data got %h want 0", data_o); else npass++;
      ntotal++; if (dut.fill_q !== 7'd0) $display("FAIL reset_fill got %0d want 0", dut.fill_q); else npass++;
      ntotal++; if (dut.slip_pend_q !== 1'b0) $display("FAIL reset_slip_pend got %b want 0", dut.slip_pend_q); else npass++;
`ifdef GEARBOX_RX_SLIP_CNT_EN
      ntotal++; if (slip_cnt_o !== 16'd0) $display("FAIL reset_slip_cnt got %0d want 0", slip_cnt_o); else npass++;
`endif
      serdes_v_i = 1'b0;
      slip_i = 1'b0;
      nreset = 1'b1;
   endtask

   task automatic test_aligned();
      int bad;
      int vbad = 0;
      do_reset();
      build(64, 0);
      clear_sched();
      run(66, 2);
      ntotal++; if (nrx !== 64) $display("FAIL aligned_count got %0d want 64", nrx); else npass++;
      bad = count_bad(0, 64);
      ntotal++; if (bad !== 0) $display("FAIL aligned_blocks got %0d bad blocks want 0 (rx0=%h)", bad, rx[0]); else npass++;
      for (int w = 0; w < 66; w++)
         if (vhist[w] !== ((w != 0) && (w != 33))) vbad++;
      ntotal++; if (vbad !== 0) $display("FAIL aligned_valid_cadence got %0d bad cycles want 0", vbad); else npass++;
      ntotal++;
      if ({data_o, head_o} !== exp_blk(63) || valid_o !== 1'b0)
         $display("FAIL aligned_hold got %h/%b want %h/0", {data_o, head_o}, valid_o, exp_blk(63));
      else npass++;
   endtask

   task automatic test_one_bit_offset();
      int bad;
      do_reset();
      build(64, 1);
      clear_sched();
      slip_at[0] = 1'b1;
      run(67, 2);
      ntotal++; if (nrx !== 64) $display("FAIL offset1_count got %0d want 64", nrx); else npass++;
      bad = count_bad(0, 64);
      ntotal++; if (bad !== 0) $display("FAIL offset1_blocks got %0d bad blocks want 0", bad); else npass++;
`ifdef GEARBOX_RX_SLIP_CNT_EN
      ntotal++; if (slip_cnt_o !== 16'd1) $display("FAIL offset1_slip_cnt got %0d want 1", slip_cnt_o); else npass++;
`endif
   endtask

   task automatic test_slip_65();
      int bad = 0;
      do_reset();
      build(128, 65);
      clear_sched();
      for (int i = 0; i < 65; i++) slip_at[i] = 1'b1;
      run(134, 2);
      // 62 misaligned blocks leave while slipping, then blocks 62..127 realign.
      ntotal++; if (nrx !== 128) $display("FAIL slip65_count got %0d want 128", nrx); else npass++;
      bad = count_bad(62, 66);
      ntotal++; if (bad !== 0) $display("FAIL slip65_blocks got %0d bad blocks want 0", bad); else npass++;
      ntotal++; if (fillhist[0] !== 63 || fillhist[1] !== 60) $display("FAIL slip65_one_bit_per_cycle got fill %0d,%0d want 63,60", fillhist[0], fillhist[1]); else npass++;
      ntotal++; if (fillmax > 65) $display("FAIL slip65_fill_max got %0d want <=65", fillmax); else npass++;
`ifdef GEARBOX_RX_SLIP_CNT_EN
      ntotal++; if (slip_cnt_o !== 16'd65) $display("FAIL slip65_slip_cnt got %0d want 65", slip_cnt_o); else npass++;
`endif
   endtask

   task automatic test_gaps();
      int bad;
      int gbad = 0;
      do_reset();
      build(64, 0);
      clear_sched();
      for (int i = 2; i <= 4; i++) gap_at[i] = 1'b1;
      for (int i = 30; i <= 32; i++) gap_at[i] = 1'b1;
      for (int i = 50; i <= 52; i++) gap_at[i] = 1'b1;
      run(66, 2);
      ntotal++; if (nrx !== 64) $display("FAIL gaps_count got %0d want 64", nrx); else npass++;
      bad = count_bad(0, 64);
      ntotal++; if (bad !== 0) $display("FAIL gaps_blocks got %0d bad blocks want 0", bad); else npass++;
      for (int i = 0; i < 80; i++)
         if (gap_at[i] && vhist[i] !== 1'b0) gbad++;
      ntotal++; if (gbad !== 0) $display("FAIL gaps_valid_low got %0d gap cycles with valid want 0", gbad); else npass++;
   endtask

   task automatic test_slip_no_data();
      int bad;
      do_reset();
      slip_i = 1'b1;
      serdes_v_i = 1'b0;
      @(posedge clk); #1;
      slip_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ntotal++; if (dut.slip_pend_q !== 1'b1) $display("FAIL nodata_pend got %b want 1", dut.slip_pend_q); else npass++;
      ntotal++; if (valid_o !== 1'b0 || dut.fill_q !== 7'd0) $display("FAIL nodata_idle got valid %b fill %0d want 0 0", valid_o, dut.fill_q); else npass++;
      build(64, 1);
      clear_sched();
      run(67, 2);
      ntotal++; if (nrx !== 64) $display("FAIL nodata_count got %0d want 64", nrx); else npass++;
      bad = count_bad(0, 64);
      ntotal++; if (bad !== 0) $display("FAIL nodata_blocks got %0d bad blocks want 0", bad); else npass++;
`ifdef GEARBOX_RX_SLIP_CNT_EN
      ntotal++; if (slip_cnt_o !== 16'd1) $display("FAIL nodata_slip_cnt got %0d want 1", slip_cnt_o); else npass++;
`endif
   endtask

   task automatic test_reset_mid_stream();
      int bad;
      do_reset();
      build(64, 0);
      clear_sched();
      run(18, 0);
      ntotal++; if (nrx !== 17) $display("FAIL midrst_pre_count got %0d want 17", nrx); else npass++;
      nreset = 1'b0;
      serdes_v_i = 1'b1;
      serdes_data_i = 64'h1234_5678_9ABC_DEF0;
      @(posedge clk); #1;
      nreset = 1'b1;
      serdes_v_i = 1'b0;
      ntotal++; if (valid_o !== 1'b0 || dut.fill_q !== 7'd0) $display("FAIL midrst_state got valid %b fill %0d want 0 0", valid_o, dut.fill_q); else npass++;
      run(66, 2);
      ntotal++; if (vhist[0] !== 1'b0 || vhist[1] !== 1'b1) $display("FAIL midrst_first_block got v0=%b v1=%b want 0 1", vhist[0], vhist[1]); else npass++;
      ntotal++; if (nrx !== 64) $display("FAIL midrst_count got %0d want 64", nrx); else npass++;
      bad = count_bad(0, 64);
      ntotal++; if (bad !== 0) $display("FAIL midrst_blocks got %0d bad blocks want 0", bad); else npass++;
   endtask

   initial begin
      nreset = 1'b0;
      serdes_v_i = 1'b0;
      serdes_data_i = 64'd0;
      slip_i = 1'b0;
      test_reset();
      test_aligned();
      test_one_bit_offset();
      test_slip_65();
      test_gaps();
      test_slip_no_data();
      test_reset_mid_stream();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
